// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle controller for the npc core.
// Sequences fetch -> decode/execute -> load/store, traps on bus errors or a
// stalled access (watchdog), parks on ebreak and strobes retire.
// Optional performance counters: define MULTICYCLE_CTRL_PERF_EN.
module multicycle_ctrl #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned TO_W    = 8,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_ls,
  input  logic             id_halt,
  input  logic             ifu_rvalid,
  input  logic             ifu_err,
  input  logic             lsu_done,
  input  logic             lsu_err,
  output logic             ifu_req,
  output logic             lsu_req,
  output logic             reg_we,
  output logic             retire,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic             halted,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] inst_cnt
);

  typedef enum logic [2:0] {
    S_INIT = 3'b000,
    S_IF   = 3'b001,
    S_ID   = 3'b011,
    S_LS   = 3'b010,
    S_TRAP = 3'b100,
    S_HALT = 3'b101
  } state_t;

  localparam logic [1:0] CAUSE_IFU = 2'd1;
  localparam logic [1:0] CAUSE_LSU = 2'd2;
  localparam logic [1:0] CAUSE_TO  = 2'd3;

  // Watchdog is live only with a nonzero limit; last count before the trap.
  localparam bit            TO_EN   = (TIMEOUT != 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_EN ? TO_W'(TIMEOUT - 1) : '0;

  state_t          r_state;
  logic [TO_W-1:0] r_wdog;
  logic            r_trap;
  logic [1:0]      r_cause;
  logic            r_halted;

  logic w_in_if;
  logic w_in_id;
  logic w_in_ls;
  logic w_wdog_last;
  logic w_if_timeout;
  logic w_ls_timeout;
  logic w_id_alu;
  logic w_ls_ok;

  // State decodes and event qualifiers
  assign w_in_if      = (r_state == S_IF);
  assign w_in_id      = (r_state == S_ID);
  assign w_in_ls      = (r_state == S_LS);
  assign w_wdog_last  = TO_EN && (r_wdog == TO_LAST);
  assign w_if_timeout = w_wdog_last && !ifu_err && !ifu_rvalid;
  assign w_ls_timeout = w_wdog_last && !lsu_err && !lsu_done;
  assign w_id_alu     = w_in_id && !id_halt && !id_ls;
  assign w_ls_ok      = w_in_ls && !lsu_err && lsu_done;

  // Requests and write/retire strobes decoded from state and inputs
  assign ifu_req = w_in_if;
  assign lsu_req = w_in_ls || (w_in_id && id_ls && !id_halt);
  assign reg_we  = w_id_alu || w_ls_ok;
  assign retire  = w_id_alu || w_ls_ok;

  assign trap       = r_trap;
  assign trap_cause = r_cause;
  assign halted     = r_halted;
  assign state_o    = r_state;

  // Controller FSM with watchdog and sticky trap/halt status
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_INIT;
      r_wdog   <= '0;
      r_trap   <= 1'b0;
      r_cause  <= 2'd0;
      r_halted <= 1'b0;
    end else begin
      case (r_state)
        S_INIT: begin
          r_state <= S_IF;
          r_wdog  <= '0;
        end
        S_IF: begin
          if (ifu_err) begin
            r_state <= S_TRAP;
            r_trap  <= 1'b1;
            r_cause <= CAUSE_IFU;
            r_wdog  <= '0;
          end else if (ifu_rvalid) begin
            r_state <= S_ID;
            r_wdog  <= '0;
          end else if (w_if_timeout) begin
            r_state <= S_TRAP;
            r_trap  <= 1'b1;
            r_cause <= CAUSE_TO;
            r_wdog  <= '0;
          end else if (r_wdog != '1) begin
            r_wdog <= r_wdog + TO_W'(1);
          end
        end
        S_ID: begin
          r_wdog <= '0;
          if (id_halt) begin
            r_state  <= S_HALT;
            r_halted <= 1'b1;
          end else if (id_ls) begin
            r_state <= S_LS;
          end else begin
            r_state <= S_IF;
          end
        end
        S_LS: begin
          if (lsu_err) begin
            r_state <= S_TRAP;
            r_trap  <= 1'b1;
            r_cause <= CAUSE_LSU;
            r_wdog  <= '0;
          end else if (lsu_done) begin
            r_state <= S_IF;
            r_wdog  <= '0;
          end else if (w_ls_timeout) begin
            r_state <= S_TRAP;
            r_trap  <= 1'b1;
            r_cause <= CAUSE_TO;
            r_wdog  <= '0;
          end else if (r_wdog != '1) begin
            r_wdog <= r_wdog + TO_W'(1);
          end
        end
        S_TRAP: begin
          r_state <= S_TRAP;
        end
        S_HALT: begin
          r_state <= S_HALT;
        end
        default: begin
          r_state <= S_INIT;
          r_wdog  <= '0;
        end
      endcase
    end
  end

`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [CNT_W-1:0] r_cyc_cnt;
  logic [CNT_W-1:0] r_inst_cnt;

  // Active-cycle and retired-instruction counters, wrapping
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cyc_cnt  <= '0;
      r_inst_cnt <= '0;
    end else begin
      if (w_in_if || w_in_id || w_in_ls) begin
        r_cyc_cnt <= r_cyc_cnt + CNT_W'(1);
      end
      if (retire) begin
        r_inst_cnt <= r_inst_cnt + CNT_W'(1);
      end
    end
  end

  assign cyc_cnt  = r_cyc_cnt;
  assign inst_cnt = r_inst_cnt;
`else
  assign cyc_cnt  = '0;
  assign inst_cnt = '0;
`endif

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Parametrised successor to the single-issue multi-cycle CPU controller FSM; sequences fetch -> decode/execute -> load/store for the npc core.
- Adds bus-error and watchdog-timeout trapping, an ebreak halt state, a retire strobe and optional performance counters.
- Sits between IFU, IDU and LSU.
- Drives the fetch request, the LSU request and the register-file write enable.

Parameters:
- TIMEOUT, 16, max wait cycles in IF or LS before a timeout trap; 0 disables the watchdog.
- TO_W, 8, watchdog counter width; must satisfy 2^TO_W > TIMEOUT.
- CNT_W, 32, performance counter width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous active-high
- id_ls  in  1  decoded instruction is load/store; valid in ID
- id_halt  in  1  decoded ebreak; valid in ID
- ifu_rvalid  in  1  instruction fetch complete
- ifu_err  in  1  fetch bus error
- lsu_done  in  1  data read or write complete
- lsu_err  in  1  data bus error
- ifu_req  out  1  fetch request
- lsu_req  out  1  data access request
- reg_we  out  1  register-file write enable, one-cycle pulse
- retire  out  1  instruction retired, one-cycle pulse
- trap  out  1  sticky trap flag
- trap_cause  out  2  0 none, 1 ifu_err, 2 lsu_err, 3 timeout
- halted  out  1  sticky ebreak halt
- state_o  out  3  current state encoding
- cyc_cnt  out  CNT_W  cycle counter (optional feature)
- inst_cnt  out  CNT_W  retired-instruction counter (optional feature)

Behaviour:
- State encodings: INIT=000, IF=001, ID=011, LS=010, TRAP=100, HALT=101. Any other encoding -> INIT next cycle.
- Reset, evaluated at the clk edge: state=INIT, watchdog=0, trap=0, trap_cause=0, halted=0, counters=0. All request and pulse outputs are 0 while in INIT.
- INIT -> IF unconditionally (1 cycle).
- IF: ifu_req=1.
  - ifu_err -> TRAP, cause 1.
  - else ifu_rvalid -> ID.
  - else timeout -> TRAP, cause 3.
  - else stay in IF.
- ID: lsu_req=id_ls & ~id_halt.
  - id_halt -> HALT, no write, no retire. id_halt has priority over id_ls.
  - id_ls -> LS.
  - else reg_we=1, retire=1, -> IF.
- LS: lsu_req=1.
  - lsu_err -> TRAP, cause 2, no write.
  - else lsu_done -> reg_we=1, retire=1, -> IF.
  - else timeout -> TRAP, cause 3.
  - else stay in LS.
- Priority in IF/LS: error > completion > timeout. A completion in the same cycle the timeout would fire wins.
- Watchdog:
  - Cleared on every state change.
  - Increments each cycle spent in IF or LS; saturates, no wrap.
  - Timeout condition: TIMEOUT!=0 and watchdog==TIMEOUT-1 and no end/err this cycle. A stalled request therefore traps on its TIMEOUT-th cycle in the state.
- TRAP and HALT are absorbing until rst.
  - In both: ifu_req=lsu_req=reg_we=retire=0.
  - trap=1 in TRAP; halted=1 in HALT.
  - trap_cause holds its value.
- reg_we and retire are combinational from state and inputs, identical in timing.
- trap, halted and trap_cause are registered; they assert the cycle the state enters TRAP/HALT.
- Reset asserted mid-wait (IF or LS) aborts the access: requests drop the next cycle. Late ifu_rvalid or lsu_done in INIT is ignored.

Optional Feature:
- Macro: MULTICYCLE_CTRL_PERF_EN.
- Defined:
  - cyc_cnt increments every cycle outside INIT, TRAP and HALT.
  - inst_cnt increments on retire.
  - Both wrap modulo 2^CNT_W and reset to 0.
- Undefined: cyc_cnt and inst_cnt tied to 0; no counter flops.

Test Plan:
- ALU instr: rst 2 cycles, ifu_rvalid on 3rd IF cycle, id_ls=0 -> states INIT,IF,IF,IF,ID,IF; reg_we=retire=1 exactly in the ID cycle.
- Load: IF done, id_ls=1, lsu_done after 4 LS cycles -> lsu_req high in ID and in all 4 LS cycles; reg_we pulses on the 4th LS cycle; back to IF.
- Timeout: TIMEOUT=16, hold ifu_rvalid=0 -> TRAP entered after the 16th IF cycle; trap=1, trap_cause=3, ifu_req=0 thereafter. Same run with TIMEOUT=0 -> no trap after 100 cycles.
- Simultaneous events: lsu_done=lsu_err=1 in LS -> TRAP cause 2, reg_we=0. ifu_rvalid on the cycle watchdog==15 (TIMEOUT=16) -> ID, no trap.
- Halt: id_halt=id_ls=1 in ID -> HALT, halted=1, lsu_req=0, retire=0. rst then returns to INIT with halted=0.
- Perf (macro defined): 3 ALU instrs with 1-cycle fetch -> inst_cnt=3, cyc_cnt=6 on the cycle after the 3rd retire.
